demux_1x16_collector: RTL and testbench
=======================================

// Module: demux_1x16_collector
// PURPOSE
//  Receiving end of the 16:1 bit-select mux path: takes a serial bit stream tagged with a
//  lane select, routes each bit to its lane (registered 1:16 demux), and reassembles a full
//  16-bit word once lanes 0..N-1 arrive in ascending order. Sits downstream of mux_16X1
//  when that mux is swept sel=0..15 to serialise a word; recovers the original word.
// PARAMETERS
//  N      16  number of lanes / word width (power of 2, >=2)
//  SEL_W  4   select width, = log2(N)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous, active-high reset
//  din        in   1      serial data bit (the mux y output)
//  sel        in   SEL_W  lane index of din
//  din_valid  in   1      din/sel qualify this cycle
//  out        out  N      registered demux: out[sel]=din, all other lanes 0
//  word       out  N      last fully assembled word (holds until next completes)
//  word_valid out  1      one-cycle pulse: word just updated
//  seq_err    out  1      one-cycle pulse: out-of-order sel detected
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): out=0, word=0, word_valid=0, seq_err=0, shadow buffer=0,
//    exp=0, state=IDLE. Reset wins over any concurrent din_valid; mid-word reset drops
//    the partial word, word not updated.
//  - Demux path, latency 1: each cycle out<=0; if din_valid, out[sel]<=din. No valid -> 0.
//  - Assembly FSM, expected-index counter exp (SEL_W bits):
//    IDLE: din_valid && sel==0 -> buf[0]<=din, exp<=1, ->COLLECT. Other sel ignored, no err.
//    COLLECT, din_valid && sel==exp: buf[exp]<=din; if exp==N-1: word<={din,buf[N-2:0]},
//      word_valid<=1 next cycle, exp<=0, ->IDLE; else exp<=exp+1.
//    COLLECT, din_valid && sel!=exp: seq_err<=1 (1 cycle), partial discarded; if sel==0
//      restart (buf[0]<=din, exp<=1, stay COLLECT) else exp<=0, ->IDLE.
//    COLLECT, !din_valid: hold state, gaps of any length allowed.
//  - word_valid and seq_err are registered, asserted the cycle after the causing beat,
//    never both high; word changes only in the cycle word_valid is high.
//  - Back-to-back words: beat sel=0 the cycle after sel=N-1 starts the next word with no
//    bubble (completion returns to IDLE, IDLE accepts sel=0 immediately).
//  - exp never wraps by increment: exp==N-1 completion explicitly loads 0.
// TESTING
//  1 Sweep sel=0..15 consecutively, din=bits of 16'b1010111100001010 (LSB at sel=0) ->
//    word=16'hAF0A, word_valid high exactly 1 cycle after sel=15 beat, seq_err never.
//  2 Demux: din_valid=1, sel=5, din=1 -> next cycle out=16'h0020; din_valid=0 -> out=0.
//  3 Same sweep as 1 with din_valid low for 3 cycles between sel=7 and sel=8 ->
//    identical word=16'hAF0A, word_valid once.
//  4 Sweep 0..6 then sel=9 -> seq_err 1 cycle, no word_valid, word unchanged; then full
//    0..15 sweep of 16'h1234 -> word=16'h1234.
//  5 Two sweeps back-to-back (16'hAF0A then 16'h5555) -> two word_valid pulses 16 cycles
//    apart, word=16'hAF0A then 16'h5555.
//  6 rst=1 for 1 cycle after sel=10 beat, then sweep 16'hFFFF -> all outputs 0 after reset,
//    word=16'hFFFF after sweep, no seq_err.

Source files
------------

// File: rtl/demux_1x16_collector.sv
// Registered 1:N bit demux plus an in-order word collector that recovers an
// N-bit word serialised as ascending lane beats 0..N-1.
module demux_1x16_collector #(
    parameter int N     = 16,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic [SEL_W-1:0] sel,
    input  logic             din_valid,
    output logic [N-1:0]     out,
    output logic [N-1:0]     word,
    output logic             word_valid,
    output logic             seq_err
);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N - 1);
    localparam logic [SEL_W-1:0] ZERO_SEL = '0;
    localparam logic [SEL_W-1:0] ONE_SEL  = SEL_W'(1);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] exp_q, exp_d;
    logic [N-1:0]     shadow_q, shadow_d;
    logic [N-1:0]     out_q, out_d;
    logic [N-1:0]     word_q, word_d;
    logic             word_valid_q, word_valid_d;
    logic             seq_err_q, seq_err_d;

    logic             beat_in_order;
    logic             beat_is_zero;
    logic             beat_is_last;

    assign beat_in_order = din_valid && (sel == exp_q);
    assign beat_is_zero  = din_valid && (sel == ZERO_SEL);
    assign beat_is_last  = (exp_q == LAST_SEL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            exp_q        <= '0;
            shadow_q     <= '0;
            out_q        <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            seq_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            exp_q        <= exp_d;
            shadow_q     <= shadow_d;
            out_q        <= out_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
            seq_err_q    <= seq_err_d;
        end
    end

    // A completed word returns to IDLE so a sel=0 beat in the very next cycle
    // starts the following word without a bubble.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (beat_is_zero) begin
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (beat_in_order) begin
                    if (beat_is_last) begin
                        state_d = IDLE;
                    end
                end else if (din_valid && !beat_is_zero) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_d        = '0;
        exp_d        = exp_q;
        shadow_d     = shadow_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        seq_err_d    = 1'b0;

        if (din_valid) begin
            out_d[sel] = din;
        end

        unique case (state_q)
            IDLE: begin
                if (beat_is_zero) begin
                    shadow_d    = '0;
                    shadow_d[0] = din;
                    exp_d       = ONE_SEL;
                end
            end
            COLLECT: begin
                if (beat_in_order) begin
                    shadow_d[exp_q] = din;
                    if (beat_is_last) begin
                        word_d       = {din, shadow_q[N-2:0]};
                        word_valid_d = 1'b1;
                        exp_d        = '0;
                    end else begin
                        exp_d = exp_q + ONE_SEL;
                    end
                end else if (din_valid) begin
                    // Out-of-order beat: drop the partial word; a sel=0 beat
                    // is still a legal start of a new word.
                    seq_err_d = 1'b1;
                    shadow_d  = '0;
                    if (beat_is_zero) begin
                        shadow_d[0] = din;
                        exp_d       = ONE_SEL;
                    end else begin
                        exp_d = '0;
                    end
                end
            end
            default: begin
                exp_d    = '0;
                shadow_d = '0;
            end
        endcase
    end

    assign out        = out_q;
    assign word       = word_q;
    assign word_valid = word_valid_q;
    assign seq_err    = seq_err_q;

endmodule

// File: tb/tb_demux_1x16_collector.sv
// Scoreboard bench for demux_1x16_collector: stimulus queues timed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_demux_1x16_collector;

    localparam int EV_NONE = 0;
    localparam int EV_WORD = 1;
    localparam int EV_ERR  = 2;
    localparam int EV_RST  = 3;

    typedef struct {
        int          due;
        logic [15:0] val;
    } outExp_t;

    typedef struct {
        int          due;
        int          kind;
        logic [15:0] val;
    } evExp_t;

    logic        clk;
    logic        rst;
    logic        din;
    logic [3:0]  sel;
    logic        dinValid;
    logic [15:0] out;
    logic [15:0] word;
    logic        wordValid;
    logic        seqErr;

    outExp_t     outQ[$];
    evExp_t      evQ[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] expWord = '0;

    demux_1x16_collector #(.N(16), .SEL_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .sel        (sel),
        .din_valid  (dinValid),
        .out        (out),
        .word       (word),
        .word_valid (wordValid),
        .seq_err    (seqErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s cyc=%0d got=%h expected=%h", name, cyc, actual, expected);
        end
    endtask

    // One beat per call; the expected demux value and any expected pulse are
    // due at the negedge following the capturing posedge.
    task automatic applyStimulus(input logic r, input logic v, input logic [3:0] s, input logic d,
                                 input int kind, input logic [15:0] val);
        outExp_t o;
        evExp_t  e;
        @(posedge clk);
        #1;
        rst      = r;
        dinValid = v;
        sel      = s;
        din      = d;
        o.due = cyc + 1;
        o.val = '0;
        if (v && !r) o.val[s] = d;
        outQ.push_back(o);
        if (kind != EV_NONE) begin
            e.due  = cyc + 1;
            e.kind = kind;
            e.val  = val;
            evQ.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, EV_NONE, 16'h0);
    endtask

    // Beats sel=0..count-1 carrying bits of w; a full sweep must yield word w.
    task automatic sweep(input logic [15:0] w, input int count, input int gapAfter, input int gapLen);
        for (int i = 0; i < count; i++) begin
            applyStimulus(1'b0, 1'b1, 4'(i), w[i], (i == 15) ? EV_WORD : EV_NONE, w);
            if (i == gapAfter) idle(gapLen);
        end
    endtask

    always @(negedge clk) begin
        logic expWv;
        logic expSe;
        if (cyc > 0) begin
            expWv = 1'b0;
            expSe = 1'b0;
            if (outQ.size() > 0 && outQ[0].due == cyc) begin
                checkOutput("out", out, outQ[0].val);
                void'(outQ.pop_front());
            end
            if (evQ.size() > 0 && evQ[0].due == cyc) begin
                case (evQ[0].kind)
                    EV_WORD: begin expWv = 1'b1; expWord = evQ[0].val; end
                    EV_ERR:  expSe = 1'b1;
                    EV_RST:  expWord = '0;
                    default: ;
                endcase
                void'(evQ.pop_front());
            end
            checkOutput("word_valid", {15'h0, wordValid}, {15'h0, expWv});
            checkOutput("seq_err", {15'h0, seqErr}, {15'h0, expSe});
            checkOutput("word", word, expWord);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        din      = 1'b0;
        sel      = '0;
        dinValid = 1'b0;

        applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, EV_RST, 16'h0);
        applyStimulus(1'b1, 1'b1, 4'd0, 1'b1, EV_RST, 16'h0);
        idle(2);

        $display("[TB] plain sweep AF0A");
        sweep(16'hAF0A, 16, -1, 0);
        idle(2);

        $display("[TB] demux lane 5");
        applyStimulus(1'b0, 1'b1, 4'd5, 1'b1, EV_NONE, 16'h0);
        applyStimulus(1'b0, 1'b0, 4'd5, 1'b1, EV_NONE, 16'h0);
        applyStimulus(1'b0, 1'b1, 4'd15, 1'b1, EV_NONE, 16'h0);
        applyStimulus(1'b0, 1'b1, 4'd3, 1'b0, EV_NONE, 16'h0);
        idle(1);

        $display("[TB] sweep with gap after sel=7");
        sweep(16'hAF0A, 16, 7, 3);
        idle(2);

        $display("[TB] out-of-order then 1234");
        sweep(16'hAF0A, 7, -1, 0);
        applyStimulus(1'b0, 1'b1, 4'd9, 1'b1, EV_ERR, 16'h0);
        idle(1);
        sweep(16'h1234, 16, -1, 0);
        idle(1);

        $display("[TB] restart on sel=0 mid-word");
        sweep(16'hFFFF, 4, -1, 0);
        applyStimulus(1'b0, 1'b1, 4'd0, 1'b0, EV_ERR, 16'h0);
        for (int i = 1; i < 16; i++) begin
            applyStimulus(1'b0, 1'b1, 4'(i), 1'b0, (i == 15) ? EV_WORD : EV_NONE, 16'h0000);
        end
        idle(1);

        $display("[TB] back-to-back AF0A, 5555");
        sweep(16'hAF0A, 16, -1, 0);
        sweep(16'h5555, 16, -1, 0);
        idle(2);

        $display("[TB] mid-word reset then FFFF");
        sweep(16'h1234, 11, -1, 0);
        applyStimulus(1'b1, 1'b1, 4'd11, 1'b1, EV_RST, 16'h0);
        sweep(16'hFFFF, 16, -1, 0);
        idle(3);

        @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("outQ_drained", 16'(outQ.size()), 16'h0);
        checkOutput("evQ_drained", 16'(evQ.size()), 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
